// File: rtl/issue_scheduler.sv
// Issue/writeback scheduler: pops ready FIFO heads round-robin and books each
// result's CDB cycle at issue time. Define ISSUE_SCHED_PERF_EN for stall counters.
module issue_scheduler #(
    parameter int NUM_Q     = 4,
    parameter int INT_LAT   = 1,
    parameter int MUL_LAT   = 4,
    parameter int DIV_LAT   = 8,
    parameter int LS_LAT    = 2,
    parameter int MAX_ISSUE = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic [NUM_Q-1:0] i_q_empty,
    input  logic [NUM_Q-1:0] i_q_rs1_rdy,
    input  logic [NUM_Q-1:0] i_q_rs2_rdy,
    output logic [NUM_Q-1:0] o_q_rd_en,
    output logic             o_cdb_valid,
    output logic [1:0]       o_cdb_owner,
    output logic             o_div_busy
`ifdef ISSUE_SCHED_PERF_EN
    ,
    output logic [31:0]      o_stall_slot_cnt,
    output logic [31:0]      o_stall_div_cnt
`endif
);

    function automatic int lat_of(input int idx);
        case (idx)
            32'sd0:  lat_of = INT_LAT;
            32'sd1:  lat_of = MUL_LAT;
            32'sd2:  lat_of = DIV_LAT;
            default: lat_of = LS_LAT;
        endcase
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAXL    = max2(max2(INT_LAT, MUL_LAT), max2(DIV_LAT, LS_LAT));
    localparam int LIDX_W  = $clog2(MAXL + 1);
    localparam int PTR_W   = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;
    localparam int CNT_W   = $clog2(DIV_LAT + 1);
    localparam int DIV_IDX = 2;

    logic [MAXL:0]      r_res_v;
    logic [1:0]         r_res_id [0:MAXL];
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]   r_div_cnt;
    logic               r_div_busy;

    logic [NUM_Q-1:0]   w_ready;
    logic [NUM_Q-1:0]   w_cand;
    logic [NUM_Q-1:0]   w_grant;
    logic [MAXL:1]      w_set_v;
    logic [1:0]         w_set_id [1:MAXL];
    logic [PTR_W-1:0]   w_rr_next;

    // Per-FIFO eligibility: operands ready, CDB slot free, DIV idle, no flush/reset
    always_comb begin
        w_ready = '0;
        w_cand  = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            w_ready[i] = !i_q_empty[i] && i_q_rs1_rdy[i] && i_q_rs2_rdy[i];
            w_cand[i]  = w_ready[i] && !r_res_v[LIDX_W'(lat_of(i))]
                         && !((i == DIV_IDX) && r_div_busy) && !i_flush && i_rst_n;
        end
    end

    // Round-robin grant of up to MAX_ISSUE candidates; a slot goes to the first claimant
    always_comb begin
        int  n;
        int  idx;
        logic take;
        n         = 0;
        idx       = 0;
        take      = 1'b0;
        w_grant   = '0;
        w_set_v   = '0;
        w_rr_next = r_rr_ptr;
        for (int j = 1; j <= MAXL; j++) begin
            w_set_id[j] = 2'b00;
        end
        for (int k = 0; k < NUM_Q; k++) begin
            idx  = (int'(r_rr_ptr) + k) % NUM_Q;
            take = w_cand[PTR_W'(idx)] && !w_set_v[LIDX_W'(lat_of(idx))] && (n < MAX_ISSUE);
            w_grant[PTR_W'(idx)]             = take;
            w_set_v[LIDX_W'(lat_of(idx))]    = w_set_v[LIDX_W'(lat_of(idx))] | take;
            w_set_id[LIDX_W'(lat_of(idx))]   = take ? 2'(idx) : w_set_id[LIDX_W'(lat_of(idx))];
            w_rr_next = take ? PTR_W'((idx + 1) % NUM_Q) : w_rr_next;
            n = n + (take ? 1 : 0);
        end
    end

    // Reservation table: shift one slot per cycle, insert new bookings at their latency
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_res_v <= '0;
            for (int k = 0; k <= MAXL; k++) r_res_id[k] <= 2'b00;
        end else if (i_flush) begin
            r_res_v <= '0;
            for (int k = 0; k <= MAXL; k++) r_res_id[k] <= 2'b00;
        end else begin
            for (int k = 0; k < MAXL; k++) begin
                r_res_v[k]  <= r_res_v[k+1] | w_set_v[k+1];
                r_res_id[k] <= w_set_v[k+1] ? w_set_id[k+1] : r_res_id[k+1];
            end
            r_res_v[MAXL]  <= 1'b0;
            r_res_id[MAXL] <= 2'b00;
        end
    end

    // Round-robin pointer; flush blocks all grants so the pointer holds through it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr_ptr <= '0;
        end else begin
            r_rr_ptr <= w_rr_next;
        end
    end

    // Unpipelined divider occupancy: busy for DIV_LAT-1 cycles after a grant
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div_cnt  <= '0;
            r_div_busy <= 1'b0;
        end else if (i_flush) begin
            r_div_cnt  <= '0;
            r_div_busy <= 1'b0;
        end else if (w_grant[DIV_IDX]) begin
            r_div_cnt  <= CNT_W'(DIV_LAT - 1);
            r_div_busy <= (DIV_LAT > 1);
        end else if (r_div_busy) begin
            r_div_cnt  <= r_div_cnt - CNT_W'(1);
            r_div_busy <= (r_div_cnt != CNT_W'(1));
        end else begin
            r_div_cnt  <= r_div_cnt;
            r_div_busy <= r_div_busy;
        end
    end

    assign o_q_rd_en   = w_grant;
    assign o_cdb_valid = r_res_v[0];
    assign o_cdb_owner = r_res_id[0];
    assign o_div_busy  = r_div_busy;

`ifdef ISSUE_SCHED_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? (v + 32'd1) : v;
    endfunction

    logic [NUM_Q-1:0] w_slot_blk;
    logic             w_div_blk;
    logic [31:0]      r_stall_slot_cnt;
    logic [31:0]      r_stall_div_cnt;

    // Heads stalled purely by an occupied CDB slot, and DIV heads stalled by busy
    always_comb begin
        w_slot_blk = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            w_slot_blk[i] = w_ready[i] && r_res_v[LIDX_W'(lat_of(i))]
                            && !((i == DIV_IDX) && r_div_busy);
        end
        w_div_blk = w_ready[DIV_IDX] && r_div_busy;
    end

    // Saturating stall counters, frozen during flush
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_slot_cnt <= 32'd0;
            r_stall_div_cnt  <= 32'd0;
        end else if (i_flush) begin
            r_stall_slot_cnt <= r_stall_slot_cnt;
            r_stall_div_cnt  <= r_stall_div_cnt;
        end else begin
            r_stall_slot_cnt <= sat_inc(r_stall_slot_cnt, |w_slot_blk);
            r_stall_div_cnt  <= sat_inc(r_stall_div_cnt, w_div_blk);
        end
    end

    assign o_stall_slot_cnt = r_stall_slot_cnt;
    assign o_stall_div_cnt  = r_stall_div_cnt;
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
// Randomized self-checking bench for issue_scheduler; the reference model books
// results in an absolute-cycle CDB calendar and tracks the divider's free time.
module tb_issue_scheduler;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_flush;
    logic [3:0] i_q_empty;
    logic [3:0] i_q_rs1_rdy;
    logic [3:0] i_q_rs2_rdy;
    logic [3:0] o_q_rd_en;
    logic       o_cdb_valid;
    logic [1:0] o_cdb_owner;
    logic       o_div_busy;

    always #5 i_clk = ~i_clk;

    issue_scheduler dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_flush     (i_flush),
        .i_q_empty   (i_q_empty),
        .i_q_rs1_rdy (i_q_rs1_rdy),
        .i_q_rs2_rdy (i_q_rs2_rdy),
        .o_q_rd_en   (o_q_rd_en),
        .o_cdb_valid (o_cdb_valid),
        .o_cdb_owner (o_cdb_owner),
        .o_div_busy  (o_div_busy)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit slot_v  [0:8191];
    int slot_id [0:8191];
    int div_free = 0;
    int rr       = 0;

    function automatic int m_lat(input int u);
        case (u)
            0:       return 1;
            1:       return 4;
            2:       return 8;
            default: return 2;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < 8192; c++) begin
            slot_v[c]  = 1'b0;
            slot_id[c] = 0;
        end
        div_free = 0;
        rr       = 0;
    endtask

    task automatic tick(input logic [3:0] emp, input logic [3:0] r1, input logic [3:0] r2,
                        input logic fl);
        logic [3:0] exp_g;
        int n;
        int idx;
        int last;
        bit taken [0:15];
        i_q_empty   = emp;
        i_q_rs1_rdy = r1;
        i_q_rs2_rdy = r2;
        i_flush     = fl;
        #2;
        exp_g = 4'b0000;
        n     = 0;
        last  = -1;
        for (int t = 0; t < 16; t++) taken[t] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = (rr + k) % 4;
            if (!emp[idx] && r1[idx] && r2[idx] && !fl && !slot_v[cyc + m_lat(idx)]
                && !(idx == 2 && cyc < div_free) && !taken[m_lat(idx)] && n < 2) begin
                exp_g[idx]        = 1'b1;
                taken[m_lat(idx)] = 1'b1;
                n++;
                last = idx;
            end
        end
        check("rd_en", {28'd0, o_q_rd_en}, {28'd0, exp_g});
        check("cdb_valid", {31'd0, o_cdb_valid}, {31'd0, slot_v[cyc]});
        if (slot_v[cyc]) check("cdb_owner", {30'd0, o_cdb_owner}, slot_id[cyc]);
        check("div_busy", {31'd0, o_div_busy}, (cyc < div_free) ? 32'd1 : 32'd0);
        if (fl) begin
            for (int c = cyc + 1; c <= cyc + 10; c++) slot_v[c] = 1'b0;
            div_free = 0;
        end else begin
            for (int u = 0; u < 4; u++) begin
                if (exp_g[u]) begin
                    slot_v[cyc + m_lat(u)]  = 1'b1;
                    slot_id[cyc + m_lat(u)] = u;
                    if (u == 2) div_free = cyc + 8;
                end
            end
            if (last >= 0) rr = (last + 1) % 4;
        end
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    task automatic go(input logic [3:0] mask, input int n);
        for (int i = 0; i < n; i++) tick(~mask, 4'hF, 4'hF, 1'b0);
    endtask

    task automatic idle(input int n);
        go(4'b0000, n);
    endtask

    task automatic check_in_reset();
        check("rst_rd_en", {28'd0, o_q_rd_en}, 32'd0);
        check("rst_cdb_valid", {31'd0, o_cdb_valid}, 32'd0);
        check("rst_cdb_owner", {30'd0, o_cdb_owner}, 32'd0);
        check("rst_div_busy", {31'd0, o_div_busy}, 32'd0);
    endtask

    // Asserts reset between clock edges; outputs must clear without waiting for an edge
    task automatic async_reset();
        #1;
        i_q_empty   = 4'b0000;
        i_q_rs1_rdy = 4'hF;
        i_q_rs2_rdy = 4'hF;
        i_flush     = 1'b0;
        i_rst_n     = 1'b0;
        #1;
        check_in_reset();
        model_clear();
        @(posedge i_clk);
        #1;
        cyc++;
        i_rst_n = 1'b1;
    endtask

    initial begin
        i_rst_n     = 1'b0;
        i_flush     = 1'b0;
        i_q_empty   = 4'b0000;
        i_q_rs1_rdy = 4'hF;
        i_q_rs2_rdy = 4'hF;
        model_clear();
        repeat (2) @(posedge i_clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            #2;
            check_in_reset();
            @(posedge i_clk);
            #1;
            cyc++;
        end
        i_rst_n = 1'b1;
        idle(2);

        go(4'b0001, 3); idle(3);
        go(4'b0010, 1); idle(2); go(4'b0001, 2); idle(3);
        go(4'b0100, 9); idle(10);
        go(4'b1000, 1); idle(10);
        go(4'b1111, 2); idle(10); go(4'b1111, 1); idle(10);
        tick(4'b1110, 4'b1110, 4'hF, 1'b0); tick(4'b1110, 4'hF, 4'b1110, 1'b0); idle(2);
        go(4'b0010, 1); idle(1); tick(4'b0000, 4'hF, 4'hF, 1'b1); idle(4);
        go(4'b0100, 1); idle(2); tick(4'b0000, 4'hF, 4'hF, 1'b1); go(4'b0100, 1); idle(10);
        go(4'b1111, 2); async_reset(); idle(3);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
            end else begin
                tick(4'($urandom), 4'($urandom | $urandom), 4'($urandom | $urandom),
                     ($urandom_range(0, 19) == 0));
            end
        end
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
